elbeth_hazard_ctrl: RTL and testbench
=====================================

// Module: elbeth_hazard_ctrl
// PURPOSE
//  Parametrised hazard controller for the ELBETH pipeline; extends single-stage forwarding.
//  Generates per-source forwarding selects from EX/MEM/WB, load-use stalls, and long-latency
//  stalls via a pending-write scoreboard. Also sequences multi-cycle flushes on taken branches.
//  Sits beside the ID stage and drives the IF/ID stall and flush controls.
// PARAMETERS
//  NUM_SRC       2   source operands per instruction (rs1..rsN)
//  ADDR_W        5   register address width
//  PEND_DEPTH    4   scoreboard entries (outstanding long-latency writes), >=1
//  FLUSH_CYCLES  2   cycles flush_id stays asserted after a taken branch, >=1
// PORTS
//  clk           in   1               pipeline clock, rising edge
//  rst_n         in   1               asynchronous active-low reset
//  id_valid      in   1               valid instruction in ID
//  id_rs_addr    in   NUM_SRC*ADDR_W  source addresses; src i = [i*ADDR_W +: ADDR_W]
//  id_rs_used    in   NUM_SRC         source i actually read
//  id_rd_addr    in   ADDR_W          ID destination
//  id_w_gpr_en   in   1               ID writes GPR
//  id_long_op    in   1               ID op is long-latency (div/ext load)
//  ex_rd_addr    in   ADDR_W          EX destination
//  ex_w_gpr_en   in   1               EX writes GPR
//  ex_is_load    in   1               EX op is a load
//  mem_rd_addr   in   ADDR_W          MEM destination
//  mem_w_gpr_en  in   1               MEM writes GPR
//  wb_rd_addr    in   ADDR_W          WB destination
//  wb_w_gpr_en   in   1               WB writes GPR
//  lop_done      in   1               long op completes this cycle
//  lop_rd_addr   in   ADDR_W          completing long op destination
//  branch_taken  in   1               taken branch resolved in EX
//  fwd_sel       out  NUM_SRC*2       per src: 00 regfile, 01 EX, 10 MEM, 11 WB
//  stall_if      out  1               hold PC / IF-ID register
//  stall_id      out  1               hold ID, inject bubble into EX
//  flush_id      out  1               squash IF/ID contents
//  sb_full       out  1               all scoreboard entries valid
// BEHAVIOUR
//  - Reset (rst_n=0, async): scoreboard cleared, FSM IDLE, flush counter 0; all outputs 0.
//  - match(s,X): id_rs_used[s] & X_w_gpr_en & X_rd==src addr & src addr!=0. x0 never matches.
//  - fwd_sel[s] priority EX > MEM > WB (youngest wins); combinational, zero latency.
//  - Load-use: match(s,EX) & ex_is_load -> stall; fwd_sel[s] falls to MEM/WB/00 that cycle.
//  - Scoreboard hit: src s equals a valid entry addr -> stall, even if lop_done for it is
//    this cycle (release next cycle; value then read via WB forward or regfile).
//  - Structural: id_long_op & id_w_gpr_en & sb_full -> stall.
//  - stall_id = stall_if = id_valid & (load-use | sb hit | structural) & ~flush_id.
//  - Issue: id_valid & id_long_op & id_w_gpr_en & id_rd!=0 & ~stall_id & ~flush_id writes
//    id_rd into lowest free entry on clk edge.
//  - Retire: lop_done clears the lowest valid entry with matching addr; no match -> ignored.
//  - Same-edge retire+issue: retire first, then issue; freed slot reusable same edge.
//  - Duplicate rd in scoreboard allowed; each lop_done retires one entry.
//  - sb_full = popcount(valid)==PEND_DEPTH, registered-state derived.
//  - FSM IDLE->FLUSH on branch_taken; counter loads FLUSH_CYCLES-1; flush_id=1 in FLUSH;
//    decrements each cycle; FLUSH->IDLE when counter==0. branch_taken in FLUSH reloads.
//  - Flush beats stall: flush_id=1 forces stall_id=stall_if=0 and blocks issue.
//  - Scoreboard is never flushed (issued long ops are pre-branch, still complete).
// TESTING
//  1 src0=x5, EX rd=x5 w_en, MEM rd=x5 w_en -> fwd_sel[1:0]=01; rs=x0 -> 00.
//  2 EX load rd=x7, src1=x7 -> stall_id=stall_if=1 one cycle; next cycle MEM fwd, sel=10.
//  3 Issue long op rd=x9; next instr reads x9 -> stall until lop_done(x9); released next cycle.
//  4 PEND_DEPTH=4: issue 4 long ops -> sb_full=1; 5th stalls; lop_done+issue same edge -> 4.
//  5 branch_taken with FLUSH_CYCLES=2 -> flush_id=1 for 2 cycles, stall suppressed;
//    branch_taken again in FLUSH -> reloads counter.
//  6 Drop rst_n mid-FLUSH with 3 entries -> outputs 0 immediately, sb empty, IDLE.

Source files
------------

// File: rtl/elbeth_hazard_ctrl.sv
// ELBETH ID-stage hazard controller: EX/MEM/WB forwarding selects, load-use and
// long-latency scoreboard stalls, and a multi-cycle flush sequencer for taken branches.
module elbeth_hazard_ctrl #(
  parameter int NUM_SRC      = 2,
  parameter int ADDR_W       = 5,
  parameter int PEND_DEPTH   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]   id_rs_addr,
  input  logic [NUM_SRC-1:0]          id_rs_used,
  input  logic [ADDR_W-1:0]           id_rd_addr,
  input  logic                        id_w_gpr_en,
  input  logic                        id_long_op,
  input  logic [ADDR_W-1:0]           ex_rd_addr,
  input  logic                        ex_w_gpr_en,
  input  logic                        ex_is_load,
  input  logic [ADDR_W-1:0]           mem_rd_addr,
  input  logic                        mem_w_gpr_en,
  input  logic [ADDR_W-1:0]           wb_rd_addr,
  input  logic                        wb_w_gpr_en,
  input  logic                        lop_done,
  input  logic [ADDR_W-1:0]           lop_rd_addr,
  input  logic                        branch_taken,
  output logic [NUM_SRC*2-1:0]        fwd_sel,
  output logic                        stall_if,
  output logic                        stall_id,
  output logic                        flush_id,
  output logic                        sb_full
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PEND_DEPTH-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0]   addr_q [PEND_DEPTH];
  logic [ADDR_W-1:0]   addr_d [PEND_DEPTH];

  logic [NUM_SRC*2-1:0] fwd_raw;
  logic                 lu_any, hit_any, struct_hz, flush_int, stall_int, issue;
  logic                 ret_done, iss_done;
  logic                 ex_m, mem_m, wb_m, use_s;
  logic [ADDR_W-1:0]    src;

  // Per-source hazard detection; a load in EX cannot forward, so it drops to older stages.
  always_comb begin
    fwd_raw = '0;
    lu_any  = 1'b0;
    hit_any = 1'b0;
    src     = '0;
    use_s   = 1'b0;
    ex_m    = 1'b0;
    mem_m   = 1'b0;
    wb_m    = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src   = id_rs_addr[s*ADDR_W +: ADDR_W];
      use_s = id_rs_used[s] && (src != '0);
      ex_m  = use_s && ex_w_gpr_en  && (ex_rd_addr  == src);
      mem_m = use_s && mem_w_gpr_en && (mem_rd_addr == src);
      wb_m  = use_s && wb_w_gpr_en  && (wb_rd_addr  == src);
      if (ex_m && ex_is_load) lu_any = 1'b1;
      if (ex_m && !ex_is_load) fwd_raw[2*s +: 2] = 2'b01;
      else if (mem_m)          fwd_raw[2*s +: 2] = 2'b10;
      else if (wb_m)           fwd_raw[2*s +: 2] = 2'b11;
      for (int e = 0; e < PEND_DEPTH; e++) begin
        if (use_s && vld_q[e] && (addr_q[e] == src)) hit_any = 1'b1;
      end
    end
  end

  assign sb_full   = &vld_q;
  assign struct_hz = id_long_op && id_w_gpr_en && sb_full;
  assign stall_int = id_valid && (lu_any || hit_any || struct_hz) && !flush_int;
  assign issue     = id_valid && id_long_op && id_w_gpr_en && (id_rd_addr != '0)
                     && !stall_int && !flush_int;

  // Retire before issue so a slot freed this edge can be refilled on the same edge.
  always_comb begin
    vld_d    = vld_q;
    addr_d   = addr_q;
    ret_done = 1'b0;
    iss_done = 1'b0;
    if (lop_done) begin
      for (int e = 0; e < PEND_DEPTH; e++) begin
        if (!ret_done && vld_q[e] && (addr_q[e] == lop_rd_addr)) begin
          vld_d[e] = 1'b0;
          ret_done = 1'b1;
        end
      end
    end
    if (issue) begin
      for (int e = 0; e < PEND_DEPTH; e++) begin
        if (!iss_done && !vld_d[e]) begin
          vld_d[e]  = 1'b1;
          addr_d[e] = id_rd_addr;
          iss_done  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (branch_taken) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (branch_taken)       cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        else if (cnt_q == '0)   state_d = IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_int = (state_q == FLUSH);
  end

  // Combinational outputs are forced quiet while reset is held.
  assign fwd_sel  = rst_n ? fwd_raw : '0;
  assign stall_id = rst_n && stall_int;
  assign stall_if = rst_n && stall_int;
  assign flush_id = flush_int;

endmodule

// File: tb/tb_elbeth_hazard_ctrl.sv
// Bench for elbeth_hazard_ctrl: multiset scoreboard + flush-remaining model checked every
// cycle, plus directed vectors with literal expectations.
module tb_elbeth_hazard_ctrl;
  localparam int NS = 2;
  localparam int AW = 5;
  localparam int PD = 4;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_w_gpr_en, id_long_op;
  logic [NS*AW-1:0] id_rs_addr;
  logic [NS-1:0] id_rs_used;
  logic [AW-1:0] id_rd_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr, lop_rd_addr;
  logic ex_w_gpr_en, ex_is_load, mem_w_gpr_en, wb_w_gpr_en, lop_done, branch_taken;
  logic [NS*2-1:0] fwd_sel;
  logic stall_if, stall_id, flush_id, sb_full;

  int npass = 0;
  int ntot  = 0;
  bit run_chk = 1'b0;

  int q[$];
  int rem = 0;

  elbeth_hazard_ctrl #(.NUM_SRC(NS), .ADDR_W(AW), .PEND_DEPTH(PD), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_w_gpr_en(id_w_gpr_en),
    .id_long_op(id_long_op), .ex_rd_addr(ex_rd_addr), .ex_w_gpr_en(ex_w_gpr_en),
    .ex_is_load(ex_is_load), .mem_rd_addr(mem_rd_addr), .mem_w_gpr_en(mem_w_gpr_en),
    .wb_rd_addr(wb_rd_addr), .wb_w_gpr_en(wb_w_gpr_en), .lop_done(lop_done),
    .lop_rd_addr(lop_rd_addr), .branch_taken(branch_taken), .fwd_sel(fwd_sel),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .sb_full(sb_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int src_of(input int s);
    return int'(id_rs_addr[s*AW +: AW]);
  endfunction

  function automatic logic [NS*2-1:0] exp_fwd();
    logic [NS*2-1:0] f = '0;
    for (int s = 0; s < NS; s++) begin
      int a = src_of(s);
      if (id_rs_used[s] && a != 0) begin
        if (ex_w_gpr_en && int'(ex_rd_addr) == a && !ex_is_load) f[2*s +: 2] = 2'd1;
        else if (mem_w_gpr_en && int'(mem_rd_addr) == a)         f[2*s +: 2] = 2'd2;
        else if (wb_w_gpr_en && int'(wb_rd_addr) == a)           f[2*s +: 2] = 2'd3;
      end
    end
    return f;
  endfunction

  function automatic logic exp_stall();
    logic hz = 1'b0;
    for (int s = 0; s < NS; s++) begin
      int a = src_of(s);
      if (id_rs_used[s] && a != 0) begin
        if (ex_w_gpr_en && ex_is_load && int'(ex_rd_addr) == a) hz = 1'b1;
        foreach (q[k]) if (q[k] == a) hz = 1'b1;
      end
    end
    if (id_long_op && id_w_gpr_en && q.size() == PD) hz = 1'b1;
    return id_valid && hz && (rem == 0);
  endfunction

  // Model state advance: retire one matching address, then accept a new issue.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        rem = 0;
      end else begin
        logic st;
        int idx[$];
        st = exp_stall();
        if (lop_done) begin
          idx = q.find_first_index(x) with (x == int'(lop_rd_addr));
          if (idx.size() > 0) q.delete(idx[0]);
        end
        if (id_valid && id_long_op && id_w_gpr_en && id_rd_addr != '0 && !st && rem == 0)
          q.push_back(int'(id_rd_addr));
        if (branch_taken) rem = FC;
        else if (rem > 0) rem--;
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      if (!rst_n) begin
        chk("m_fwd_rst", 32'(fwd_sel), 32'd0);
        chk("m_stall_rst", {30'd0, stall_id, stall_if}, 32'd0);
        chk("m_flush_rst", 32'(flush_id), 32'd0);
        chk("m_full_rst", 32'(sb_full), 32'd0);
      end else begin
        chk("m_fwd", 32'(fwd_sel), 32'(exp_fwd()));
        chk("m_stall", {30'd0, stall_id, stall_if}, {30'd0, exp_stall(), exp_stall()});
        chk("m_flush", 32'(flush_id), 32'(rem > 0));
        chk("m_full", 32'(sb_full), 32'(q.size() == PD));
      end
    end
  end

  task automatic clr();
    id_valid = 0; id_rs_addr = '0; id_rs_used = '0; id_rd_addr = '0; id_w_gpr_en = 0;
    id_long_op = 0; ex_rd_addr = '0; ex_w_gpr_en = 0; ex_is_load = 0; mem_rd_addr = '0;
    mem_w_gpr_en = 0; wb_rd_addr = '0; wb_w_gpr_en = 0; lop_done = 0; lop_rd_addr = '0;
    branch_taken = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic srcs(input int a0, input bit u0, input int a1, input bit u1);
    id_rs_addr[0 +: AW]  = AW'(a0);
    id_rs_addr[AW +: AW] = AW'(a1);
    id_rs_used = {u1, u0};
  endtask

  task automatic lop(input int rd);
    id_valid = 1; id_long_op = 1; id_w_gpr_en = 1; id_rd_addr = AW'(rd);
  endtask

  initial begin
    rst_n = 0;
    clr();
    id_valid = 1; srcs(5, 1, 0, 0); ex_rd_addr = 5; ex_w_gpr_en = 1; ex_is_load = 1;
    run_chk = 1;
    @(negedge clk);
    chk("rst_stall", 32'(stall_id), 32'd0);
    chk("rst_fwd", 32'(fwd_sel), 32'd0);
    @(posedge clk); #1; rst_n = 1; clr();

    // Forwarding priority and x0
    id_valid = 1; srcs(5, 1, 0, 1); ex_rd_addr = 5; ex_w_gpr_en = 1;
    mem_rd_addr = 5; mem_w_gpr_en = 1;
    @(negedge clk); chk("fwd_ex", 32'(fwd_sel), 32'h1);
    cyc(); ex_w_gpr_en = 0;
    @(negedge clk); chk("fwd_mem", 32'(fwd_sel), 32'h2);
    cyc(); mem_w_gpr_en = 0; wb_rd_addr = 5; wb_w_gpr_en = 1; srcs(5, 1, 5, 1);
    @(negedge clk); chk("fwd_wb", 32'(fwd_sel), 32'hF);

    // Load-use
    cyc(); clr(); id_valid = 1; srcs(0, 0, 7, 1); ex_rd_addr = 7; ex_w_gpr_en = 1; ex_is_load = 1;
    @(negedge clk); chk("lu_stall_id", 32'(stall_id), 32'd1);
    chk("lu_stall_if", 32'(stall_if), 32'd1); chk("lu_fwd", 32'(fwd_sel), 32'h0);
    cyc(); clr(); id_valid = 1; srcs(0, 0, 7, 1); mem_rd_addr = 7; mem_w_gpr_en = 1;
    @(negedge clk); chk("lu_rel", 32'(stall_id), 32'd0); chk("lu_fwd_mem", 32'(fwd_sel), 32'h8);

    // Long op scoreboard hit
    cyc(); clr(); lop(9);
    @(negedge clk); chk("sb_issue", 32'(stall_id), 32'd0);
    cyc(); clr(); id_valid = 1; srcs(9, 1, 0, 0);
    @(negedge clk); chk("sb_hit1", 32'(stall_id), 32'd1);
    cyc(); @(negedge clk); chk("sb_hit2", 32'(stall_id), 32'd1);
    cyc(); lop_done = 1; lop_rd_addr = 9;
    @(negedge clk); chk("sb_hit_done", 32'(stall_id), 32'd1);
    cyc(); lop_done = 0; wb_rd_addr = 9; wb_w_gpr_en = 1;
    @(negedge clk); chk("sb_rel", 32'(stall_id), 32'd0); chk("sb_rel_fwd", 32'(fwd_sel), 32'h3);

    // Fill, structural stall, same-edge retire+issue, absent retire
    for (int i = 0; i < 4; i++) begin cyc(); clr(); lop(10 + i); end
    cyc(); clr(); lop(14);
    @(negedge clk); chk("full", 32'(sb_full), 32'd1); chk("struct_stall", 32'(stall_id), 32'd1);
    cyc(); lop_done = 1; lop_rd_addr = 10;
    @(negedge clk); chk("struct_hold", 32'(stall_id), 32'd1);
    cyc(); lop_rd_addr = 11;
    @(negedge clk); chk("full3", 32'(sb_full), 32'd0); chk("reissue", 32'(stall_id), 32'd0);
    cyc(); lop_done = 0; lop(15);
    @(negedge clk); chk("still3", 32'(sb_full), 32'd0);
    cyc(); clr();
    @(negedge clk); chk("full_again", 32'(sb_full), 32'd1);
    cyc(); lop_done = 1; lop_rd_addr = 12;
    cyc(); lop_rd_addr = 31;
    cyc(); lop_done = 0; lop(16);
    cyc(); clr();
    @(negedge clk); chk("absent_ignored", 32'(sb_full), 32'd1);
    for (int i = 13; i <= 16; i++) begin cyc(); lop_done = 1; lop_rd_addr = AW'(i); end
    cyc(); clr(); id_valid = 1; srcs(13, 1, 16, 1);
    @(negedge clk); chk("sb_empty", 32'(stall_id), 32'd0);

    // Flush sequencing, stall suppression, issue blocked
    cyc(); clr(); id_valid = 1; srcs(7, 1, 0, 0); ex_rd_addr = 7; ex_w_gpr_en = 1;
    ex_is_load = 1; branch_taken = 1;
    @(negedge clk); chk("br_flush0", 32'(flush_id), 32'd0); chk("br_stall0", 32'(stall_id), 32'd1);
    cyc(); branch_taken = 0; id_long_op = 1; id_w_gpr_en = 1; id_rd_addr = 20;
    @(negedge clk); chk("fl1", 32'(flush_id), 32'd1); chk("fl1_stall", 32'(stall_if), 32'd0);
    cyc(); @(negedge clk); chk("fl2", 32'(flush_id), 32'd1);
    cyc(); clr(); @(negedge clk); chk("fl_end", 32'(flush_id), 32'd0);
    cyc(); id_valid = 1; srcs(20, 1, 0, 0);
    @(negedge clk); chk("fl_no_issue", 32'(stall_id), 32'd0);
    cyc(); clr(); branch_taken = 1;
    cyc(); @(negedge clk); chk("rl1", 32'(flush_id), 32'd1);
    cyc(); branch_taken = 0; @(negedge clk); chk("rl2", 32'(flush_id), 32'd1);
    cyc(); @(negedge clk); chk("rl3", 32'(flush_id), 32'd1);
    cyc(); @(negedge clk); chk("rl_end", 32'(flush_id), 32'd0);

    // Async reset mid-flush with 3 pending entries
    cyc(); clr(); lop(1);
    cyc(); lop(2);
    cyc(); lop(3);
    cyc(); clr(); branch_taken = 1;
    cyc(); branch_taken = 0; id_valid = 1; srcs(1, 1, 0, 0); ex_rd_addr = 1; ex_w_gpr_en = 1;
    @(negedge clk); chk("pre_rst_flush", 32'(flush_id), 32'd1);
    chk("pre_rst_fwd", 32'(fwd_sel), 32'h1);
    #2; rst_n = 0; #1;
    chk("rst_flush", 32'(flush_id), 32'd0); chk("rst_fwd2", 32'(fwd_sel), 32'h0);
    chk("rst_stall2", 32'(stall_id), 32'd0); chk("rst_full", 32'(sb_full), 32'd0);
    @(posedge clk); #2; rst_n = 1; ex_w_gpr_en = 0;
    @(negedge clk); chk("post_rst_sb", 32'(stall_id), 32'd0);
    chk("post_rst_idle", 32'(flush_id), 32'd0);
    cyc(); clr(); cyc();
    @(negedge clk);
    run_chk = 0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
